ext_code_seq: RTL and testbench



---
 rtl/ext_code_seq_pkg.sv | 16 +
 rtl/ext_code_seq_if.sv | 33 +++
 rtl/ext_code_seq_trig_sync_edge.sv | 39 +++
 rtl/ext_code_seq.sv | 152 +++++++++++++++
 tb/tb_ext_code_seq.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_code_seq_pkg.sv
// Shared types and defaults for the external-code sequencer family.
package ext_code_pkg;

    localparam int CODE_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    localparam logic STEP_DOWN = 1'b0;
    localparam logic STEP_UP   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } seqState_t;

endpackage

// File: rtl/ext_code_seq_if.sv
// Host/trigger bundle for ext_code_seq: host strobes, mode pins, trigger in, code/status out.
interface ext_code_seq_if #(
    parameter int CODE_W = 32,
    parameter int DEPTH  = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              iSET_CODE_FLAG;
    logic [CODE_W-1:0] iSET_CODE;
    logic              iSET_INDEX_FLAG;
    logic [IDX_W-1:0]  iSET_INDEX;
    logic              iMODE_UP;
    logic              iMODE_WRAP;
    logic              iTrigger;
    logic [CODE_W-1:0] oCode;
    logic              oActive;
    logic              oDone;
    logic [IDX_W-1:0]  oIndex;
    logic              oReject;

    modport master (
        output iSET_CODE_FLAG, iSET_CODE, iSET_INDEX_FLAG, iSET_INDEX,
               iMODE_UP, iMODE_WRAP, iTrigger,
        input  oCode, oActive, oDone, oIndex, oReject
    );

    modport slave (
        input  iSET_CODE_FLAG, iSET_CODE, iSET_INDEX_FLAG, iSET_INDEX,
               iMODE_UP, iMODE_WRAP, iTrigger,
        output oCode, oActive, oDone, oIndex, oReject
    );

endinterface

// File: rtl/ext_code_seq_trig_sync_edge.sv
// trig_sync_edge: 2-flop synchroniser plus registered edge detector with rise/fall pulses.
module trig_sync_edge (
    input  logic iClk,
    input  logic iRst,
    input  logic iAsync,
    output logic oRise,
    output logic oFall
);

    logic       syncQ1;
    logic       syncQ2;
    logic       prevQ;
    logic [1:0] fillQ;
    logic       armed;

    // Edges are suppressed until a genuine low has passed through the synchroniser,
    // so a level still held high across reset never looks like a fresh rise.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncQ1 <= 1'b0;
            syncQ2 <= 1'b0;
            prevQ  <= 1'b0;
            fillQ  <= 2'b00;
            armed  <= 1'b0;
        end else begin
            syncQ1 <= iAsync;
            syncQ2 <= syncQ1;
            prevQ  <= syncQ2;
            fillQ  <= {fillQ[0], 1'b1};
            if (fillQ[1] && !syncQ2) begin
                armed <= 1'b1;
            end
        end
    end

    assign oRise = armed &  syncQ2 & ~prevQ;
    assign oFall = armed & ~syncQ2 &  prevQ;

endmodule

// File: rtl/ext_code_seq.sv
// Parametrised external-code sequencer: host-loaded code table stepped by a synchronised trigger.
// Optional debug outputs are enabled with `define EXT_CODE_SEQ_DEBUG_EN.
module ext_code_seq
    import ext_code_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic iClk,
    input  logic iRst,
    ext_code_seq_if.slave bus
`ifdef EXT_CODE_SEQ_DEBUG_EN
    ,
    output logic [1:0]        oDBG_STATE,
    output logic [CODE_W-1:0] oDBG_CUR_CODE,
    output logic [15:0]       oDBG_TRIG_CNT
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W + 1)'(DEPTH);

    seqState_t         state;
    seqState_t         stateNext;
    logic [CODE_W-1:0] storage [DEPTH];
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  indexNext;
    logic [CODE_W-1:0] codeQ;
    logic [CODE_W-1:0] codeNext;
    logic              rejectQ;
    logic              rejectNext;
    logic              trigRise;
    logic              trigFall;
    logic              hostAccept;
    logic              idxInRange;
    logic              codeWrite;
    logic              indexLoad;
    logic              atEnd;

    trig_sync_edge uTrigSync (
        .iClk  (iClk),
        .iRst  (iRst),
        .iAsync(bus.iTrigger),
        .oRise (trigRise),
        .oFall (trigFall)
    );

    // A rise in IDLE takes priority over any host strobe in the same cycle.
    always_comb begin
        hostAccept = (state == DONE) || ((state == IDLE) && !trigRise);
        idxInRange = ({1'b0, bus.iSET_INDEX} < DEPTH_L);
        codeWrite  = hostAccept && bus.iSET_CODE_FLAG;
        indexLoad  = hostAccept && bus.iSET_INDEX_FLAG && idxInRange;
        rejectNext = ((bus.iSET_CODE_FLAG || bus.iSET_INDEX_FLAG) && !hostAccept)
                   || (hostAccept && bus.iSET_INDEX_FLAG && !idxInRange);
        atEnd      = (bus.iMODE_UP == STEP_UP) ? (index == LAST_IDX) : (index == '0);
    end

    always_comb begin
        indexNext = index;
        if (indexLoad) begin
            indexNext = bus.iSET_INDEX;
        end else if ((state == ACTIVE) && trigFall) begin
            if (!atEnd) begin
                indexNext = (bus.iMODE_UP == STEP_UP) ? index + 1'b1 : index - 1'b1;
            end else if (bus.iMODE_WRAP) begin
                indexNext = (bus.iMODE_UP == STEP_UP) ? '0 : LAST_IDX;
            end
        end
    end

    always_comb begin
        codeNext = '0;
        if ((state == IDLE) && trigRise) begin
            codeNext = storage[index];
        end else if ((state == ACTIVE) && !trigFall) begin
            codeNext = codeQ;
        end
    end

    // FSM: state register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM: next state
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (trigRise) stateNext = ACTIVE;
            end
            ACTIVE: begin
                if (trigFall) stateNext = (atEnd && !bus.iMODE_WRAP) ? DONE : IDLE;
            end
            DONE: begin
                if (indexLoad) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.oActive = (state == ACTIVE);
        bus.oDone   = (state == DONE);
        bus.oIndex  = index;
        bus.oCode   = codeQ;
        bus.oReject = rejectQ;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            index   <= '0;
            codeQ   <= '0;
            rejectQ <= 1'b0;
        end else begin
            index   <= indexNext;
            codeQ   <= codeNext;
            rejectQ <= rejectNext;
        end
    end

    // Table contents survive reset; the write uses the index before any same-cycle load.
    always_ff @(posedge iClk) begin
        if (!iRst && codeWrite) begin
            storage[index] <= bus.iSET_CODE;
        end
    end

`ifdef EXT_CODE_SEQ_DEBUG_EN
    logic [15:0] trigCnt;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            trigCnt <= '0;
        end else if ((state == IDLE) && trigRise && (trigCnt != 16'hFFFF)) begin
            trigCnt <= trigCnt + 16'd1;
        end
    end

    assign oDBG_STATE    = state;
    assign oDBG_CUR_CODE = storage[index];
    assign oDBG_TRIG_CNT = trigCnt;
`endif

endmodule

// File: tb/tb_ext_code_seq.sv
// Self-checking bench for ext_code_seq: reference model feeds an expected-code queue,
// a monitor pops on every activation and checks value and trigger-to-output latency.
module tb_ext_code_seq;

    localparam int CODE_W = 32;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ext_code_seq_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) bus ();

`ifdef EXT_CODE_SEQ_DEBUG_EN
    logic [1:0]        dbg_state;
    logic [CODE_W-1:0] dbg_cur_code;
    logic [15:0]       dbg_trig_cnt;
`endif

    ext_code_seq #(.CODE_W(CODE_W), .DEPTH(DEPTH)) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
`ifdef EXT_CODE_SEQ_DEBUG_EN
        ,
        .oDBG_STATE   (dbg_state),
        .oDBG_CUR_CODE(dbg_cur_code),
        .oDBG_TRIG_CNT(dbg_trig_cnt)
`endif
    );

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: table contents, index, stopped flag, mode pins
    logic [CODE_W-1:0] m_mem [DEPTH];
    int m_idx = 0;
    bit m_done = 0;
    bit m_up = 0;
    bit m_wrap = 1;
    int exp_rej = 0;
    int rej_seen = 0;

    logic [CODE_W-1:0] exp_q[$];
    int exp_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic prev_act = 1'b0;
    always @(negedge clk) begin
        logic [CODE_W-1:0] e_code;
        int e_cyc;
        if (rst) begin
            prev_act = 1'b0;
        end else begin
            if (bus.oReject) rej_seen++;
            if (bus.oActive && !prev_act) begin
                chk("activation_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e_code = exp_q.pop_front();
                    e_cyc  = exp_cyc_q.pop_front();
                    chk("code", bus.oCode, e_code);
                    chk("latency_cycle", cyc, e_cyc);
                end
            end
            if (!bus.oActive) chk("code_zero_when_inactive", bus.oCode, 32'd0);
            prev_act = bus.oActive;
        end
    end

    // Model: what one accepted trigger pulse produces and how the index moves
    task automatic model_pulse();
        if (!m_done) begin
            exp_q.push_back(m_mem[m_idx]);
            exp_cyc_q.push_back(cyc + 3);
            if (m_up) begin
                if (m_idx == DEPTH - 1) begin
                    if (m_wrap) m_idx = 0; else m_done = 1;
                end else m_idx = m_idx + 1;
            end else begin
                if (m_idx == 0) begin
                    if (m_wrap) m_idx = DEPTH - 1; else m_done = 1;
                end else m_idx = m_idx - 1;
            end
        end
    endtask

    task automatic set_mode(input bit up, input bit wrap);
        @(negedge clk);
        m_up = up;
        m_wrap = wrap;
        bus.iMODE_UP = up;
        bus.iMODE_WRAP = wrap;
    endtask

    task automatic trig_on();
        @(negedge clk);
        bus.iTrigger = 1'b1;
        model_pulse();
    endtask

    task automatic trig_off();
        @(negedge clk);
        bus.iTrigger = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        trig_on();
        repeat (hi) @(negedge clk);
        bus.iTrigger = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic host(input bit cf, input logic [CODE_W-1:0] code, input bit xf,
                        input int idx, input bit dropped);
        @(negedge clk);
        bus.iSET_CODE_FLAG  = cf;
        bus.iSET_CODE       = code;
        bus.iSET_INDEX_FLAG = xf;
        bus.iSET_INDEX      = IDX_W'(idx);
        if (dropped) begin
            exp_rej++;
        end else begin
            if (cf) m_mem[m_idx] = code;
            if (xf) begin
                m_idx = idx;
                m_done = 0;
            end
        end
        @(negedge clk);
        bus.iSET_CODE_FLAG  = 1'b0;
        bus.iSET_INDEX_FLAG = 1'b0;
    endtask

    initial begin
        int saved_idx;
        bus.iSET_CODE_FLAG  = 1'b0;
        bus.iSET_CODE       = '0;
        bus.iSET_INDEX_FLAG = 1'b0;
        bus.iSET_INDEX      = '0;
        bus.iMODE_UP        = 1'b0;
        bus.iMODE_WRAP      = 1'b1;
        bus.iTrigger        = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_code", bus.oCode, 32'd0);
        chk("reset_active", 32'(bus.oActive), 32'd0);
        chk("reset_done", 32'(bus.oDone), 32'd0);
        chk("reset_index", 32'(bus.oIndex), 32'd0);
        chk("reset_reject", 32'(bus.oReject), 32'd0);
        repeat (4) @(negedge clk);

        // Load 0x11..0x88, step down with wrap from index 7
        for (int i = 0; i < DEPTH; i++) begin
            host(0, '0, 1, i, 0);
            host(1, CODE_W'(32'h11 * (i + 1)), 0, 0, 0);
        end
        host(0, '0, 1, 7, 0);
        set_mode(0, 1);
        for (int i = 0; i < 9; i++) pulse(4, 5);
        chk("index_after_down_wrap", 32'(bus.oIndex), 32'd6);

        // Step up, stop at end
        host(0, '0, 1, 6, 0);
        set_mode(1, 0);
        pulse(3, 5);
        pulse(3, 5);
        chk("done_at_end", 32'(bus.oDone), 32'd1);
        chk("index_held_at_end", 32'(bus.oIndex), 32'd7);
        pulse(3, 5);
        chk("done_ignores_trigger", 32'(bus.oDone), 32'd1);
        host(0, '0, 1, 0, 0);
        chk("done_exit_by_index", 32'(bus.oDone), 32'd0);
        pulse(3, 5);

        // Host write during ACTIVE is dropped
        saved_idx = m_idx;
        trig_on();
        repeat (5) @(negedge clk);
        host(1, CODE_W'(32'hDEAD), 0, 0, 1);
        trig_off();
        repeat (5) @(negedge clk);
        chk("reject_in_active", rej_seen, exp_rej);
        host(0, '0, 1, saved_idx, 0);
        pulse(3, 5);

        // Both flags together: write at old index 5, then load index 3
        host(0, '0, 1, 5, 0);
        host(1, CODE_W'(32'hBEEF), 1, 3, 0);
        chk("dual_strobe_index", 32'(bus.oIndex), 32'd3);
        host(0, '0, 1, 5, 0);
        pulse(3, 5);

        // Host strobe coincident with the synchronised rise is dropped
        saved_idx = m_idx;
        trig_on();
        @(negedge clk);
        @(negedge clk);
        bus.iSET_CODE_FLAG  = 1'b1;
        bus.iSET_CODE       = CODE_W'(32'hDEAD);
        bus.iSET_INDEX_FLAG = 1'b1;
        bus.iSET_INDEX      = '0;
        exp_rej++;
        @(negedge clk);
        bus.iSET_CODE_FLAG  = 1'b0;
        bus.iSET_INDEX_FLAG = 1'b0;
        repeat (2) @(negedge clk);
        trig_off();
        repeat (5) @(negedge clk);
        chk("reject_on_rise", rej_seen, exp_rej);
        host(0, '0, 1, saved_idx, 0);
        pulse(3, 5);

        // Reset while ACTIVE with trigger held high
        host(0, '0, 1, 4, 0);
        trig_on();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_idx = 0;
        m_done = 0;
        chk("rst_mid_code", bus.oCode, 32'd0);
        chk("rst_mid_index", 32'(bus.oIndex), 32'd0);
        chk("rst_mid_active", 32'(bus.oActive), 32'd0);
        repeat (10) @(negedge clk);
        chk("held_trigger_no_rise", 32'(bus.oActive), 32'd0);
        trig_off();
        repeat (5) @(negedge clk);
        pulse(3, 5);

        // Sub-cycle glitches never cross a sampling edge
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.iTrigger = 1'b1;
            #2;
            bus.iTrigger = 1'b0;
        end
        repeat (5) @(negedge clk);
        chk("glitch_no_activation", 32'(bus.oActive), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0, 1: begin
                    set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    pulse($urandom_range(1, 6), $urandom_range(3, 6));
                end
                2: host(1, CODE_W'($urandom), 0, 0, 0);
                3: host(0, '0, 1, $urandom_range(0, DEPTH - 1), 0);
                default: begin
                    @(negedge clk);
                    bus.iTrigger = 1'b1;
                    #2;
                    bus.iTrigger = 1'b0;
                end
            endcase
        end
        repeat (6) @(negedge clk);
        chk("random_index", 32'(bus.oIndex), 32'(m_idx));
        chk("random_done", 32'(bus.oDone), 32'(m_done));

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("reject_total", rej_seen, exp_rej);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
